control_sequencer: RTL

- Multi-cycle successor to the combinational control unit of the FRANK6000 core.
- Runs a fetch/decode/execute/writeback sequence per instruction.
- Drives the same 15-bit control word, with write strobes qualified to the writeback cycle.
- Adds a parametrised call/return stack-depth tracker with fault detection, a LOOPF halt state released by `resume`, and datapath stall support.

---
 rtl/control_sequencer_pkg.sv | 73 +++++++
 rtl/control_sequencer_decoder.sv | 32 +++
 rtl/control_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the FRANK6000 control path: opcodes, control-word
// bit positions, sequencer state encoding and the per-opcode control table.
package frank_ctrl_pkg;

  // Control word layout, bit 14 first
  localparam int unsigned CW_W         = 15;
  localparam int unsigned CW_JUMP      = 14;
  localparam int unsigned CW_JMODE_HI  = 13;
  localparam int unsigned CW_JMODE_LO  = 12;
  localparam int unsigned CW_CALL      = 11;
  localparam int unsigned CW_RET       = 10;
  localparam int unsigned CW_ADDRIN    = 9;
  localparam int unsigned CW_FRIN      = 8;
  localparam int unsigned CW_WREGIN_HI = 7;
  localparam int unsigned CW_WREGIN_LO = 6;
  localparam int unsigned CW_ALUIN1    = 5;
  localparam int unsigned CW_ALUIN2    = 4;
  localparam int unsigned CW_ADDRW     = 3;
  localparam int unsigned CW_FRW       = 2;
  localparam int unsigned CW_WREGW     = 1;
  localparam int unsigned CW_STATUSW   = 0;

  // Keeps the select field (14:4), clears the write strobes (3:0)
  localparam logic [CW_W-1:0] CW_SEL_MASK = 15'h7FF0;

  // Opcodes
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_R2_FLR = 4'h1;
  localparam logic [3:0] OP_LOOPF  = 4'h2;
  localparam logic [3:0] OP_CALL   = 4'h3;
  localparam logic [3:0] OP_RET    = 4'h4;
  localparam logic [3:0] OP_JMP    = 4'h5;
  localparam logic [3:0] OP_JZ     = 4'h6;
  localparam logic [3:0] OP_JC     = 4'h7;
  localparam logic [3:0] OP_ADD    = 4'h8;
  localparam logic [3:0] OP_LDF    = 4'h9;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  typedef struct packed {
    logic [CW_W-1:0] cw;
    logic            illegal;
  } dec_t;

  // Control-unit truth table: opcode -> control word, unlisted opcodes illegal
  function automatic dec_t cw_lookup(input logic [3:0] op);
    dec_t d;
    d.cw      = '0;
    d.illegal = 1'b0;
    case (op)
      OP_NOP:    d.cw = 15'b000000000000000;
      OP_R2_FLR: d.cw = 15'b001000000010011;
      OP_LOOPF:  d.cw = 15'b000000000000000;
      OP_CALL:   d.cw = 15'b000101000001000;
      OP_RET:    d.cw = 15'b000011000001000;
      OP_JMP:    d.cw = 15'b100001000001000;
      OP_JZ:     d.cw = 15'b101001000001000;
      OP_JC:     d.cw = 15'b110001000001000;
      OP_ADD:    d.cw = 15'b000000011100011;
      OP_LDF:    d.cw = 15'b000000100000100;
      default:   d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/control_sequencer_decoder.sv
// Combinational opcode decoder: opcode -> control word plus illegal flag.
module control_decoder
  import frank_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 4
) (
  input  logic [OPC_W-1:0] i_opcode,
  output logic [CW_W-1:0]  o_cw,
  output logic             o_illegal
);

  logic [3:0] w_op;
  logic       w_hi_set;
  dec_t       w_dec;

  // Opcodes wider than the table are illegal when any upper bit is set
  if (OPC_W > 4) begin : g_wide
    assign w_op     = i_opcode[3:0];
    assign w_hi_set = |i_opcode[OPC_W-1:4];
  end else begin : g_narrow
    assign w_op     = 4'(i_opcode);
    assign w_hi_set = 1'b0;
  end

  // Table lookup; an illegal opcode yields an all-zero word
  always_comb begin
    w_dec     = cw_lookup(w_op);
    o_illegal = w_dec.illegal | w_hi_set;
    o_cw      = o_illegal ? '0 : w_dec.cw;
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FRANK6000 control sequencer: fetch/decode/execute/writeback
// with call-depth tracking, LOOPF halt/resume, stall support and sticky fault.
module control_sequencer
  import frank_ctrl_pkg::*;
#(
  parameter  int unsigned OPC_W       = 4,
  parameter  int unsigned STACK_DEPTH = 8,
  localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_req,
  input  logic             fetch_ack,
  input  logic [OPC_W-1:0] instr_opcode,
  input  logic             stall,
  input  logic             cond_true,
  input  logic             resume,
  output logic [CW_W-1:0]  ctrl_word,
  output logic             stack_push,
  output logic             stack_pop,
  output logic [SP_W-1:0]  sp,
  output logic             halted,
  output logic             fault
);

  localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

  state_t           r_state, w_state_nxt;
  logic [OPC_W-1:0] r_opc, w_opc_nxt;
  logic [CW_W-1:0]  r_cw, w_cw_nxt;
  logic [SP_W-1:0]  r_sp, w_sp_nxt;
  logic             r_fault, w_fault_nxt;
  logic             w_fetch;
  logic [CW_W-1:0]  w_dec_cw;
  logic             w_dec_illegal;

  control_decoder #(
    .OPC_W (OPC_W)
  ) u_decoder (
    .i_opcode  (r_opc),
    .o_cw      (w_dec_cw),
    .o_illegal (w_dec_illegal)
  );

  // State, latched opcode, control word, call depth and fault flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_opc   <= '0;
      r_cw    <= '0;
      r_sp    <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_opc   <= w_opc_nxt;
      r_cw    <= w_cw_nxt;
      r_sp    <= w_sp_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Next-state and output decode for the instruction sequence
  always_comb begin
    w_state_nxt = r_state;
    w_opc_nxt   = r_opc;
    w_cw_nxt    = r_cw;
    w_sp_nxt    = r_sp;
    w_fault_nxt = r_fault;
    w_fetch     = 1'b0;
    ctrl_word   = '0;
    stack_push  = 1'b0;
    stack_pop   = 1'b0;
    halted      = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_fetch = 1'b1;
        if (fetch_ack) begin
          w_opc_nxt   = instr_opcode;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // cw_reg is only loaded at the end of DECODE, so this cycle shows the
        // decoder output directly to keep the select field visible now
        ctrl_word = w_dec_cw & CW_SEL_MASK;
        w_cw_nxt  = w_dec_cw;
        if (w_dec_illegal) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = ST_FAULT;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        ctrl_word = r_cw & CW_SEL_MASK;
        if (!stall) begin
          if (r_cw[CW_CALL] && (r_sp == SP_MAX)) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_FAULT;
          end else if (r_cw[CW_RET] && (r_sp == '0)) begin
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_FAULT;
          end else begin
            if (r_cw[CW_JUMP] && !cond_true) begin
              w_cw_nxt[CW_JUMP] = 1'b0;
            end
            w_state_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        ctrl_word = r_cw;
        if (r_cw[CW_CALL]) begin
          stack_push = 1'b1;
          w_sp_nxt   = r_sp + SP_W'(1);
        end else if (r_cw[CW_RET]) begin
          stack_pop = 1'b1;
          w_sp_nxt  = r_sp - SP_W'(1);
        end
        w_state_nxt = (r_opc == OPC_W'(OP_LOOPF)) ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (resume) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // Reset is asynchronous, so the fetch request is held off while it is asserted
  assign fetch_req = w_fetch & ~rst;
  assign sp        = r_sp;
  assign fault     = r_fault;

endmodule
